// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the load/store unit
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_OK         = 2'b00,
    LSU_MISALIGNED = 2'b01,
    LSU_ILLEGAL    = 2'b10,
    LSU_TIMEOUT    = 2'b11
  } lsu_err_t;

  // Loads use all encodings; stores only the first four (sb/sh/sw/sd).
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } mem_funct3_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane shifter, byte enables, load extender and request checks
module lsu_align
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic              store,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN/8-1:0] byte_en,
  output logic [XLEN-1:0]   load_data,
  output logic              illegal,
  output logic              misaligned
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [OFFW-1:0] off;
  logic [XLEN-1:0] shifted;
  logic [NB-1:0]   size_mask;

  assign off = addr_lo[OFFW-1:0];

  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    wdata_sh   = wdata << {off, 3'b000};
    size_mask  = '0;
    load_data  = '0;
    misaligned = 1'b0;
    illegal    = (funct3 == 3'b111) || (store && funct3[2]) ||
                 ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
    case (funct3[1:0])
      2'b00: begin
        size_mask = NB'(1);
        if (funct3[2]) load_data = XLEN'(shifted[7:0]);
        else           load_data = XLEN'($signed(shifted[7:0]));
      end
      2'b01: begin
        size_mask  = NB'(3);
        misaligned = addr_lo[0];
        if (funct3[2]) load_data = XLEN'(shifted[15:0]);
        else           load_data = XLEN'($signed(shifted[15:0]));
      end
      2'b10: begin
        size_mask  = NB'(4'hF);
        misaligned = |addr_lo[1:0];
        if (funct3[2]) load_data = XLEN'(shifted[31:0]);
        else           load_data = XLEN'($signed(shifted[31:0]));
      end
      default: begin
        size_mask  = NB'(8'hFF);
        misaligned = |addr_lo[2:0];
        load_data  = shifted;
      end
    endcase
    byte_en = size_mask << off;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM: request latch, memory access, response hold
module lsu_ctrl
  import rv32i_types::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_byte_enable,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_t      state_q, state_d;
  lsu_err_t        rsp_err_q, rsp_err_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [2:0]      addr_lo_q, addr_lo_d;
  logic            store_q, store_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [XLEN-1:0] mem_address_q, mem_address_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_be_q, mem_be_d;

  logic            idle;
  logic            timeout_hit;
  logic [XLEN-1:0] al_wdata_sh, al_load;
  logic [NB-1:0]   al_be;
  logic            al_illegal, al_misaligned;

  // In IDLE the aligner checks the incoming request; afterwards it extracts from the latched one.
  assign idle = (state_q == IDLE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (idle ? req_funct3 : funct3_q),
    .store      (idle ? req_store : store_q),
    .addr_lo    (idle ? req_addr[2:0] : addr_lo_q),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wdata_sh   (al_wdata_sh),
    .byte_en    (al_be),
    .load_data  (al_load),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rsp_err_q     <= LSU_OK;
      funct3_q      <= '0;
      addr_lo_q     <= '0;
      store_q       <= 1'b0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
    end else begin
      state_q       <= state_d;
      rsp_err_q     <= rsp_err_d;
      funct3_q      <= funct3_d;
      addr_lo_q     <= addr_lo_d;
      store_q       <= store_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rsp_err_d     = rsp_err_q;
    funct3_d      = funct3_q;
    addr_lo_d     = addr_lo_q;
    store_d       = store_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d      = req_funct3;
          addr_lo_d     = req_addr[2:0];
          store_d       = req_store;
          cnt_d         = '0;
          rsp_rdata_d   = '0;
          mem_address_d = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
          mem_wdata_d   = al_wdata_sh;
          mem_be_d      = al_be;
          if (al_illegal) begin
            rsp_err_d = LSU_ILLEGAL;
            state_d   = RESP;
          end else if (al_misaligned) begin
            rsp_err_d = LSU_MISALIGNED;
            state_d   = RESP;
          end else begin
            rsp_err_d = LSU_OK;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A response landing on the timeout cycle still completes normally.
        if (mem_resp) begin
          rsp_rdata_d = store_q ? '0 : al_load;
          rsp_err_d   = LSU_OK;
          state_d     = RESP;
        end else if (timeout_hit) begin
          rsp_err_d = LSU_TIMEOUT;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_read  = (state_q == ACCESS) && !store_q;
    mem_write = (state_q == ACCESS) && store_q;
  end

  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed checks of lsu_ctrl at XLEN=32 (TIMEOUT=4) and XLEN=64
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_store = 0, a_rsp_ready = 0, a_mresp = 0;
  logic [2:0]  a_f3 = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_mrdata = 0;
  logic        a_req_ready, a_rsp_valid, a_mread, a_mwrite;
  logic [31:0] a_rsp_rdata, a_maddr, a_mwdata;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_be;

  logic        b_valid = 0, b_store = 0, b_rsp_ready = 0, b_mresp = 0;
  logic [2:0]  b_f3 = 0;
  logic [63:0] b_addr = 0, b_wdata = 0, b_mrdata = 0;
  logic        b_req_ready, b_rsp_valid, b_mread, b_mwrite;
  logic [63:0] b_rsp_rdata, b_maddr, b_mwdata;
  logic [1:0]  b_rsp_err;
  logic [7:0]  b_be;

  int errors = 0;
  int checks = 0;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_req_ready), .req_store(a_store),
    .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_read(a_mread), .mem_write(a_mwrite), .mem_address(a_maddr),
    .mem_wdata(a_mwdata), .mem_byte_enable(a_be),
    .mem_rdata(a_mrdata), .mem_resp(a_mresp)
  );

  lsu_ctrl #(.XLEN(64), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_req_ready), .req_store(b_store),
    .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_read(b_mread), .mem_write(b_mwrite), .mem_address(b_maddr),
    .mem_wdata(b_mwdata), .mem_byte_enable(b_be),
    .mem_rdata(b_mrdata), .mem_resp(b_mresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request at +1 after an edge; mem_resp pulses in cycle k (0 = never).
  task automatic t32(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int k, input int e_lat, input int e_nstb,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [3:0] e_be, input logic [31:0] e_rdata, input logic [1:0] e_err);
    int lat, nstb;
    a_store = st; a_f3 = f3; a_addr = a; a_wdata = wd; a_mrdata = rd; a_valid = 1;
    @(posedge clk); #1;
    a_valid = 0;
    if (e_nstb > 0) begin
      check({tag, ".addr"}, a_maddr, e_addr);
      check({tag, ".be"}, a_be, e_be);
      check({tag, ".strobe"}, {a_mread, a_mwrite}, st ? 2'b01 : 2'b10);
      if (st) check({tag, ".wdata"}, a_mwdata, e_wdata);
    end
    lat = 0; nstb = 0;
    for (int c = 1; c <= 24; c++) begin
      if (a_rsp_valid) begin lat = c; break; end
      if (a_mread || a_mwrite) nstb++;
      a_mresp = (c == k);
      @(posedge clk); #1;
      a_mresp = 0;
    end
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".strobe_cycles"}, nstb, e_nstb);
    check({tag, ".rdata"}, a_rsp_rdata, e_rdata);
    check({tag, ".err"}, a_rsp_err, e_err);
    a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0;
    check({tag, ".back_to_idle"}, {a_req_ready, a_rsp_valid}, 2'b10);
  endtask

  task automatic t64(input string tag, input logic st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                     input int k, input int e_lat, input logic [63:0] e_addr,
                     input logic [63:0] e_wdata, input logic [7:0] e_be,
                     input logic [63:0] e_rdata, input logic [1:0] e_err);
    int lat;
    b_store = st; b_f3 = f3; b_addr = a; b_wdata = wd; b_mrdata = rd; b_valid = 1;
    @(posedge clk); #1;
    b_valid = 0;
    check({tag, ".addr"}, b_maddr, e_addr);
    check({tag, ".be"}, b_be, e_be);
    if (st) check({tag, ".wdata"}, b_mwdata, e_wdata);
    lat = 0;
    for (int c = 1; c <= 24; c++) begin
      if (b_rsp_valid) begin lat = c; break; end
      b_mresp = (c == k);
      @(posedge clk); #1;
      b_mresp = 0;
    end
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".rdata"}, b_rsp_rdata, e_rdata);
    check({tag, ".err"}, b_rsp_err, e_err);
    b_rsp_ready = 1;
    @(posedge clk); #1;
    b_rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset.req_ready", a_req_ready, 1);
    check("reset.rsp_valid", a_rsp_valid, 0);
    check("reset.strobes", {a_mread, a_mwrite}, 2'b00);
    check("reset.mem_address", a_maddr, 0);
    check("reset.mem_wdata", a_mwdata, 0);
    check("reset.byte_enable", a_be, 0);
    check("reset.rsp", {a_rsp_err, a_rsp_rdata}, 0);

    t32("lb",  0, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 2, 3, 2, 32'h1000, 32'h0, 4'b1000, 32'hFFFF_FF80, 2'b00);
    t32("lbu", 0, 3'b100, 32'h1003, 32'h0, 32'h80FF_0000, 2, 3, 2, 32'h1000, 32'h0, 4'b1000, 32'h0000_0080, 2'b00);
    t32("lh",  0, 3'b001, 32'h1002, 32'h0, 32'h80FF_0000, 1, 2, 1, 32'h1000, 32'h0, 4'b1100, 32'hFFFF_80FF, 2'b00);
    t32("sh",  1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 2, 1, 32'h2000, 32'hABCD_0000, 4'b1100, 32'h0, 2'b00);
    t32("lw_mis",  0, 3'b010, 32'h3001, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01);
    t32("ld_xlen32", 0, 3'b011, 32'h3000, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b10);
    t32("sb_f3_100", 1, 3'b100, 32'h3000, 32'hFF, 32'h0, 1, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b10);
    t32("f3_111_mis", 0, 3'b111, 32'h3003, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b10);
    t32("timeout", 0, 3'b010, 32'h4000, 32'h0, 32'h55, 0, 5, 4, 32'h4000, 32'h0, 4'hF, 32'h0, 2'b11);
    t32("timeout_race", 0, 3'b010, 32'h4000, 32'h0, 32'h5566_7788, 4, 5, 4, 32'h4000, 32'h0, 4'hF, 32'h5566_7788, 2'b00);

    t64("lwu", 0, 3'b110, 64'h104, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 2, 64'h100, 64'h0, 8'hF0, 64'h0000_0000_DEAD_BEEF, 2'b00);
    t64("lw64", 0, 3'b010, 64'h104, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 2, 64'h100, 64'h0, 8'hF0, 64'hFFFF_FFFF_DEAD_BEEF, 2'b00);
    t64("sd", 1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 2, 64'h108, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 2'b00);
    t64("sb64", 1, 3'b000, 64'h10D, 64'h0000_0000_0000_00A5, 64'h0, 1, 2, 64'h108, 64'h0000_A500_0000_0000, 8'h20, 64'h0, 2'b00);

    // Response held while rsp_ready is low; a new request offered meanwhile must not be taken.
    a_store = 0; a_f3 = 3'b010; a_addr = 32'h40; a_mrdata = 32'h1122_3344; a_valid = 1;
    @(posedge clk); #1;
    a_valid = 0; a_mresp = 1;
    @(posedge clk); #1;
    a_mresp = 0; a_addr = 32'h44; a_valid = 1;
    for (int i = 0; i < 3; i++) begin
      check("hold.rsp_valid", a_rsp_valid, 1);
      check("hold.rdata", a_rsp_rdata, 32'h1122_3344);
      check("hold.err_ready_strobe", {a_rsp_err, a_req_ready, a_mread}, 0);
      @(posedge clk); #1;
    end
    a_valid = 0; a_rsp_ready = 1;
    @(posedge clk); #1;
    a_rsp_ready = 0;
    check("hold.release", {a_req_ready, a_rsp_valid, a_mread}, 3'b100);

    a_f3 = 3'b010; a_addr = 32'h60; a_valid = 1;
    @(posedge clk); #1;
    a_valid = 0;
    check("rst_mid.before", a_mread, 1);
    #2 rst = 1;
    #1;
    check("rst_mid.mem_read", a_mread, 0);
    check("rst_mid.idle", {a_req_ready, a_rsp_valid}, 2'b10);
    check("rst_mid.mem_address", a_maddr, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    check("rst_mid.after", {a_req_ready, a_rsp_valid, a_mread}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
